heap_arb: RTL and testbench

Two-requester arbiter and sequencer for the linked-memory heap allocator. It accepts ALLOC/FREE/READ/WRITE requests from two independent clients (A and B) over valid/ready handshakes. It drives the allocator's single-op-per-cycle request strobes so that conflicting requests can never reach it, and routes each result back to the requester that issued it. It sits between the allocator and its clients (e.g. CPU core and collector).

---
 rtl/heap_arb_pkg.sv | 31 +++
 rtl/heap_arb_rr_arb2.sv | 32 +++
 rtl/heap_arb.sv | 197 +++++++++++++++++++
 tb/tb_heap_arb.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_arb_pkg.sv
// Shared definitions for the heap allocator front end: opcodes, port and
// state encodings, heap constants and a small opcode helper.
package heap_arb_pkg;

   // Client opcode encoding, shared by every allocator client
   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_ALLOC = 2'b10,
      OP_FREE  = 2'b11
   } op_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   // Null heap reference; also the response word for ops that return nothing
   localparam logic [15:0] NIL = 16'h0000;

   // ALLOC and READ hand a word back to the requester; FREE and WRITE do not
   function automatic logic op_has_result(input op_e op);
      return (op == OP_ALLOC) || (op == OP_READ);
   endfunction

endpackage

// File: rtl/heap_arb_rr_arb2.sv
// Two-request round-robin grant. With both requests up, the port that was
// not served last wins; the history register starts at B so A wins first.
module rr_arb2
   import heap_arb_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req_a,
   input  logic i_req_b,
   input  logic i_upd,
   output logic o_gnt_a,
   output logic o_gnt_b
);

   port_e last;

   // A wins when alone or when B was the most recent winner
   always_comb begin
      o_gnt_a = i_req_a && (!i_req_b || (last == PORT_B));
      o_gnt_b = i_req_b && !o_gnt_a;
   end

   // Record the winner of every grant that actually reaches the allocator
   // NOTE: state is only ever written with <= so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         last <= PORT_B;
      else if (i_upd && (o_gnt_a || o_gnt_b))
         last <= o_gnt_a ? PORT_A : PORT_B;
   end

endmodule

// File: rtl/heap_arb.sv
// Two-client arbiter/sequencer in front of the single-op-per-cycle heap
// allocator. Each client has a one-entry hold register; the held ops are
// granted round-robin, mapped onto one allocator strobe group, and the
// result is routed back to the issuing client one cycle later. An allocator
// error halts everything until reset.
// Optional build macro HEAP_ARB_PAIR_EN: an ALLOC and a FREE held on opposite
// ports issue together in a single cycle.
module heap_arb
   import heap_arb_pkg::*;
#(
   parameter int DATA_SZ = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_a_valid,
   output logic               o_a_ready,
   input  logic [1:0]         i_a_op,
   input  logic [DATA_SZ-1:0] i_a_addr,
   input  logic [DATA_SZ-1:0] i_a_data,
   output logic               o_a_rvalid,
   output logic [DATA_SZ-1:0] o_a_rdata,
   input  logic               i_b_valid,
   output logic               o_b_ready,
   input  logic [1:0]         i_b_op,
   input  logic [DATA_SZ-1:0] i_b_addr,
   input  logic [DATA_SZ-1:0] i_b_data,
   output logic               o_b_rvalid,
   output logic [DATA_SZ-1:0] o_b_rdata,
   output logic               o_mem_alloc,
   output logic               o_mem_free,
   output logic               o_mem_rd,
   output logic               o_mem_wr,
   output logic [DATA_SZ-1:0] o_mem_data,
   output logic [DATA_SZ-1:0] o_mem_addr,
   output logic [DATA_SZ-1:0] o_mem_waddr,
   output logic [DATA_SZ-1:0] o_mem_wdata,
   output logic [DATA_SZ-1:0] o_mem_raddr,
   input  logic [DATA_SZ-1:0] i_mem_rdata,
   input  logic               i_mem_err,
   output logic               o_err
);

   state_e             state;
   logic               live;     // low during reset and its first release cycle
   logic               gate;     // no issue, no handshake, no response
   logic               pair;
   logic               gnt_a, gnt_b;

   // Per-port views, index 0 = A, index 1 = B
   logic               valid    [2];
   op_e                req_op   [2];
   logic [DATA_SZ-1:0] req_addr [2];
   logic [DATA_SZ-1:0] req_data [2];
   logic               ready    [2];
   logic               hv       [2];
   op_e                op       [2];
   logic [DATA_SZ-1:0] addr     [2];
   logic [DATA_SZ-1:0] data     [2];
   logic               issue    [2];
   logic               resp     [2];
   op_e                resp_op  [2];
   logic               rvalid   [2];
   logic [DATA_SZ-1:0] rdata    [2];

   assign valid[0]    = i_a_valid;
   assign valid[1]    = i_b_valid;
   assign req_op[0]   = op_e'(i_a_op);
   assign req_op[1]   = op_e'(i_b_op);
   assign req_addr[0] = i_a_addr;
   assign req_addr[1] = i_b_addr;
   assign req_data[0] = i_a_data;
   assign req_data[1] = i_b_data;

   // An error seen in RUN blocks its own cycle as well as every later one
   assign gate = (state == ST_HALT) || i_mem_err;

`ifdef HEAP_ARB_PAIR_EN
   assign pair = hv[0] && hv[1] &&
                 (((op[0] == OP_ALLOC) && (op[1] == OP_FREE)) ||
                  ((op[0] == OP_FREE)  && (op[1] == OP_ALLOC)));
`else
   assign pair = 1'b0;
`endif

   rr_arb2 u_arb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_req_a (hv[0]),
      .i_req_b (hv[1]),
      .i_upd   (!gate && !pair),
      .o_gnt_a (gnt_a),
      .o_gnt_b (gnt_b)
   );

   assign issue[0] = !gate && (pair || gnt_a);
   assign issue[1] = !gate && (pair || gnt_b);

   // Handshake acceptance and response routing for both ports
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         ready[p]  = live && !gate && (!hv[p] || issue[p]);
         rvalid[p] = resp[p] && !gate;
         rdata[p]  = (rvalid[p] && op_has_result(resp_op[p])) ? i_mem_rdata : DATA_SZ'(NIL);
      end
   end

   assign o_a_ready  = ready[0];
   assign o_b_ready  = ready[1];
   assign o_a_rvalid = rvalid[0];
   assign o_b_rvalid = rvalid[1];
   assign o_a_rdata  = rdata[0];
   assign o_b_rdata  = rdata[1];

   // Map each issuing hold register onto its allocator strobe group
   // NOTE: every output gets a default first, so no path leaves a latch behind.
   always_comb begin
      o_mem_alloc = 1'b0;
      o_mem_free  = 1'b0;
      o_mem_rd    = 1'b0;
      o_mem_wr    = 1'b0;
      o_mem_data  = '0;
      o_mem_addr  = '0;
      o_mem_waddr = '0;
      o_mem_wdata = '0;
      o_mem_raddr = '0;
      for (int p = 0; p < 2; p++) begin
         if (issue[p]) begin
            case (op[p])
               OP_ALLOC: begin o_mem_alloc = 1'b1; o_mem_data  = data[p]; end
               OP_FREE:  begin o_mem_free  = 1'b1; o_mem_addr  = addr[p]; end
               OP_READ:  begin o_mem_rd    = 1'b1; o_mem_raddr = addr[p]; end
               default:  begin o_mem_wr    = 1'b1; o_mem_waddr = addr[p]; o_mem_wdata = data[p]; end
            endcase
         end
      end
   end

   // Hold registers load on handshake and empty on issue; both can coincide
   // NOTE: payload is reset along with hv so a discarded op leaves no stale operands.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int p = 0; p < 2; p++) begin
            hv[p]   <= 1'b0;
            op[p]   <= OP_READ;
            addr[p] <= '0;
            data[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (valid[p] && ready[p]) begin
               hv[p]   <= 1'b1;
               op[p]   <= req_op[p];
               addr[p] <= req_addr[p];
               data[p] <= req_data[p];
            end else if (issue[p]) begin
               hv[p] <= 1'b0;
            end
         end
      end
   end

   // Remember who issued what so next cycle's result goes back to them
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int p = 0; p < 2; p++) begin
            resp[p]    <= 1'b0;
            resp_op[p] <= OP_READ;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            resp[p]    <= issue[p];
            resp_op[p] <= op[p];
         end
      end
   end

   // RUN/HALT control with registered sticky error and reset-release qualifier
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_RUN;
         o_err <= 1'b0;
         live  <= 1'b0;
      end else begin
         live <= 1'b1;
         case (state)
            ST_RUN: begin
               if (i_mem_err) begin
                  state <= ST_HALT;
                  o_err <= 1'b1;
               end
            end
            default: state <= ST_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_heap_arb.sv
// Self-checking bench for heap_arb: directed scenarios plus a randomized run
// scored against a per-port in-order request model and a simple allocator stub.
module tb_heap_arb;
   import heap_arb_pkg::*;

   localparam int DW = 16;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_a_valid, i_b_valid;
   logic [1:0]    i_a_op, i_b_op;
   logic [DW-1:0] i_a_addr, i_a_data, i_b_addr, i_b_data;
   logic          o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid;
   logic [DW-1:0] o_a_rdata, o_b_rdata;
   logic          o_mem_alloc, o_mem_free, o_mem_rd, o_mem_wr;
   logic [DW-1:0] o_mem_data, o_mem_addr, o_mem_waddr, o_mem_wdata, o_mem_raddr;
   logic [DW-1:0] i_mem_rdata;
   logic          i_mem_err;
   logic          o_err;

   logic [3:0]    strobes;
   logic [5*DW-1:0] operands;
   assign strobes  = {o_mem_alloc, o_mem_free, o_mem_rd, o_mem_wr};
   assign operands = {o_mem_data, o_mem_addr, o_mem_waddr, o_mem_wdata, o_mem_raddr};

   int checks = 0;
   int errors = 0;

   heap_arb #(.DATA_SZ(DW)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_op(i_a_op),
      .i_a_addr(i_a_addr), .i_a_data(i_a_data), .o_a_rvalid(o_a_rvalid), .o_a_rdata(o_a_rdata),
      .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_op(i_b_op),
      .i_b_addr(i_b_addr), .i_b_data(i_b_data), .o_b_rvalid(o_b_rvalid), .o_b_rdata(o_b_rdata),
      .o_mem_alloc(o_mem_alloc), .o_mem_free(o_mem_free), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
      .o_mem_data(o_mem_data), .o_mem_addr(o_mem_addr), .o_mem_waddr(o_mem_waddr),
      .o_mem_wdata(o_mem_wdata), .o_mem_raddr(o_mem_raddr),
      .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   // Allocator stub: bump allocator from 0x5000, flat word memory, result next cycle
   logic [DW-1:0] stub_mem    [65536];
   logic [DW-1:0] alloc_data  [65536];
   logic          alloc_valid [65536];
   logic          returned    [65536];
   logic [DW-1:0] next_addr = 16'h5000;

   initial begin
      for (int i = 0; i < 65536; i++) begin
         stub_mem[i]    = '0;
         alloc_data[i]  = '0;
         alloc_valid[i] = 1'b0;
         returned[i]    = 1'b0;
      end
   end

   always @(posedge i_clk) begin
      if (i_rst) begin
         i_mem_rdata <= '0;
      end else begin
         if (o_mem_wr) stub_mem[o_mem_waddr] <= o_mem_wdata;
         if (o_mem_alloc) begin
            stub_mem[next_addr]    <= o_mem_data;
            alloc_data[next_addr]  <= o_mem_data;
            alloc_valid[next_addr] <= 1'b1;
            i_mem_rdata            <= next_addr;
            next_addr              <= next_addr + 16'd1;
         end else if (o_mem_rd) begin
            i_mem_rdata <= stub_mem[o_mem_raddr];
         end else begin
            i_mem_rdata <= '0;
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_a_valid = 1'b0; i_a_op = 2'b00; i_a_addr = '0; i_a_data = '0;
      i_b_valid = 1'b0; i_b_op = 2'b00; i_b_addr = '0; i_b_data = '0;
      i_mem_err = 1'b0;
   endtask

   task automatic apply_reset();
      i_rst = 1'b1;
      idle_inputs();
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      idle_inputs();
      #2;
      checks++;
      if ({strobes, o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid, o_err} !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 000000000", {strobes, o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid, o_err});
      end
      checks++;
      if ({operands, o_a_rdata, o_b_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", {operands, o_a_rdata, o_b_rdata});
      end
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      tick();
      @(negedge i_clk);
      checks++;
      if ({o_a_ready, o_b_ready, o_err} !== 3'b110) begin
         errors++;
         $display("FAIL reset_release ready_a,ready_b,err got %b want 110", {o_a_ready, o_b_ready, o_err});
      end
      tick();
   endtask

   task automatic test_read_write();
      i_a_valid = 1'b1; i_a_op = OP_WRITE; i_a_addr = 16'h0010; i_a_data = 16'hBEEF;
      tick();
      i_a_valid = 1'b0;
      @(negedge i_clk);
      checks++;
      if (strobes !== 4'b0001 || o_mem_waddr !== 16'h0010 || o_mem_wdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL write_issue got strb=%b waddr=%h wdata=%h want 0001 0010 beef", strobes, o_mem_waddr, o_mem_wdata);
      end
      tick();
      @(negedge i_clk);
      checks++;
      if (o_a_rvalid !== 1'b1 || o_a_rdata !== 16'h0000) begin
         errors++;
         $display("FAIL write_resp got rvalid=%b rdata=%h want 1 0000", o_a_rvalid, o_a_rdata);
      end
      tick();
      i_a_valid = 1'b1; i_a_op = OP_READ; i_a_addr = 16'h0010; i_a_data = '0;
      tick();
      i_a_valid = 1'b0;
      @(negedge i_clk);
      checks++;
      if (strobes !== 4'b0010 || o_mem_raddr !== 16'h0010 || o_mem_waddr !== 16'h0000) begin
         errors++;
         $display("FAIL read_issue got strb=%b raddr=%h waddr=%h want 0010 0010 0000", strobes, o_mem_raddr, o_mem_waddr);
      end
      tick();
      @(negedge i_clk);
      checks++;
      if (o_a_rvalid !== 1'b1 || o_a_rdata !== 16'hBEEF || o_b_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL read_resp got a_rvalid=%b a_rdata=%h b_rvalid=%b want 1 beef 0", o_a_rvalid, o_a_rdata, o_b_rvalid);
      end
      tick();
   endtask

   task automatic test_alloc_contention();
      logic [DW-1:0] ra, rb;
      apply_reset();
      i_a_valid = 1'b1; i_a_op = OP_ALLOC; i_a_data = 16'h8001;
      i_b_valid = 1'b1; i_b_op = OP_ALLOC; i_b_data = 16'h8002;
      tick();
      i_a_valid = 1'b0; i_b_valid = 1'b0;
      @(negedge i_clk);
      checks++;
      if (strobes !== 4'b1000 || o_mem_data !== 16'h8001 || o_b_ready !== 1'b0) begin
         errors++;
         $display("FAIL contend_first got strb=%b data=%h b_ready=%b want 1000 8001 0", strobes, o_mem_data, o_b_ready);
      end
      tick();
      @(negedge i_clk);
      ra = o_a_rdata;
      checks++;
      if (strobes !== 4'b1000 || o_mem_data !== 16'h8002 || o_a_rvalid !== 1'b1 || o_b_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL contend_second got strb=%b data=%h a_rv=%b b_rv=%b want 1000 8002 1 0", strobes, o_mem_data, o_a_rvalid, o_b_rvalid);
      end
      checks++;
      if (alloc_valid[ra] !== 1'b1 || alloc_data[ra] !== 16'h8001) begin
         errors++;
         $display("FAIL contend_a_addr got addr=%h holding %h want block holding 8001", ra, alloc_data[ra]);
      end
      tick();
      @(negedge i_clk);
      rb = o_b_rdata;
      checks++;
      if (o_b_rvalid !== 1'b1 || o_a_rvalid !== 1'b0 || strobes !== 4'b0000) begin
         errors++;
         $display("FAIL contend_b_resp got b_rv=%b a_rv=%b strb=%b want 1 0 0000", o_b_rvalid, o_a_rvalid, strobes);
      end
      checks++;
      if (rb === ra || alloc_valid[rb] !== 1'b1 || alloc_data[rb] !== 16'h8002) begin
         errors++;
         $display("FAIL contend_b_addr got addr=%h holding %h want distinct block holding 8002", rb, alloc_data[rb]);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int cnt_a = 0;
      int cnt_b = 0;
      logic [DW-1:0] want;
      apply_reset();
      i_a_valid = 1'b1; i_a_op = OP_READ; i_a_addr = 16'h0001;
      i_b_valid = 1'b1; i_b_op = OP_READ; i_b_addr = 16'h0011;
      tick();
      for (int k = 0; k < 10; k++) begin
         @(negedge i_clk);
         if (k < 8) begin
            want = (k % 2 == 0) ? 16'h0001 : 16'h0011;
            checks++;
            if (o_mem_rd !== 1'b1 || o_mem_raddr !== want) begin
               errors++;
               $display("FAIL rr_grant cycle %0d got rd=%b raddr=%h want 1 %h", k, o_mem_rd, o_mem_raddr, want);
            end
         end
         if (k >= 1 && k <= 8) begin
            if (o_a_rvalid === 1'b1) cnt_a++;
            if (o_b_rvalid === 1'b1) cnt_b++;
         end
         tick();
      end
      i_a_valid = 1'b0; i_b_valid = 1'b0;
      checks++;
      if (cnt_a != 4 || cnt_b != 4) begin
         errors++;
         $display("FAIL rr_responses got a=%0d b=%0d want 4 4", cnt_a, cnt_b);
      end
      repeat (4) tick();
   endtask

   task automatic test_pair();
      apply_reset();
      i_a_valid = 1'b1; i_a_op = OP_ALLOC; i_a_data = 16'h8007;
      i_b_valid = 1'b1; i_b_op = OP_FREE;  i_b_addr = 16'h5003;
      tick();
      i_a_valid = 1'b0; i_b_valid = 1'b0;
      @(negedge i_clk);
`ifdef HEAP_ARB_PAIR_EN
      checks++;
      if (strobes !== 4'b1100 || o_mem_data !== 16'h8007 || o_mem_addr !== 16'h5003) begin
         errors++;
         $display("FAIL pair_issue got strb=%b data=%h addr=%h want 1100 8007 5003", strobes, o_mem_data, o_mem_addr);
      end
      tick();
      @(negedge i_clk);
      checks++;
      if (o_a_rvalid !== 1'b1 || o_b_rvalid !== 1'b1 || o_b_rdata !== 16'h0000 ||
          alloc_valid[o_a_rdata] !== 1'b1 || alloc_data[o_a_rdata] !== 16'h8007) begin
         errors++;
         $display("FAIL pair_resp got a_rv=%b a_rdata=%h b_rv=%b b_rdata=%h want 1 block(8007) 1 0000", o_a_rvalid, o_a_rdata, o_b_rvalid, o_b_rdata);
      end
`else
      checks++;
      if (strobes !== 4'b1000 || o_mem_data !== 16'h8007 || o_mem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL serial_alloc got strb=%b data=%h addr=%h want 1000 8007 0000", strobes, o_mem_data, o_mem_addr);
      end
      tick();
      @(negedge i_clk);
      checks++;
      if (strobes !== 4'b0100 || o_mem_addr !== 16'h5003 || o_a_rvalid !== 1'b1 || o_b_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL serial_free got strb=%b addr=%h a_rv=%b b_rv=%b want 0100 5003 1 0", strobes, o_mem_addr, o_a_rvalid, o_b_rvalid);
      end
      tick();
      @(negedge i_clk);
      checks++;
      if (o_b_rvalid !== 1'b1 || o_b_rdata !== 16'h0000 || o_a_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL serial_free_resp got b_rv=%b b_rdata=%h a_rv=%b want 1 0000 0", o_b_rvalid, o_b_rdata, o_a_rvalid);
      end
`endif
      tick();
   endtask

   task automatic test_error();
      apply_reset();
      i_a_valid = 1'b1; i_a_op = OP_READ; i_a_addr = 16'h0010;
      i_b_valid = 1'b1; i_b_op = OP_READ; i_b_addr = 16'h0011;
      tick();
      i_a_valid = 1'b0; i_b_valid = 1'b0;
      @(negedge i_clk);
      checks++;
      if (strobes !== 4'b0010 || o_mem_raddr !== 16'h0010) begin
         errors++;
         $display("FAIL err_pre_issue got strb=%b raddr=%h want 0010 0010", strobes, o_mem_raddr);
      end
      tick();
      i_mem_err = 1'b1;
      #1;
      checks++;
      if (strobes !== 4'b0000 || o_a_rvalid !== 1'b0 || o_a_ready !== 1'b0 || o_b_ready !== 1'b0 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL err_cycle got strb=%b a_rv=%b ready=%b%b err=%b want 0000 0 00 0", strobes, o_a_rvalid, o_a_ready, o_b_ready, o_err);
      end
      tick();
      i_mem_err = 1'b0;
      i_a_valid = 1'b1; i_a_op = OP_WRITE; i_a_addr = 16'h0012;
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clk);
         checks++;
         if (o_err !== 1'b1 || strobes !== 4'b0000 || o_a_rvalid !== 1'b0 || o_b_rvalid !== 1'b0 ||
             o_a_ready !== 1'b0 || o_b_ready !== 1'b0) begin
            errors++;
            $display("FAIL halt_cycle %0d got err=%b strb=%b rv=%b%b ready=%b%b want 1 0000 00 00", k, o_err, strobes, o_a_rvalid, o_b_rvalid, o_a_ready, o_b_ready);
         end
         tick();
      end
      i_rst = 1'b1;
      i_a_valid = 1'b0;
      #2;
      checks++;
      if ({strobes, o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid, o_err, operands, o_a_rdata, o_b_rdata} !== '0) begin
         errors++;
         $display("FAIL halt_reset got ctrl=%b err=%b want all 0", {strobes, o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid}, o_err);
      end
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      tick();
   endtask

   task automatic test_reset_midop();
      apply_reset();
      i_a_valid = 1'b1; i_a_op = OP_ALLOC; i_a_data = 16'h1234;
      i_b_valid = 1'b1; i_b_op = OP_READ;  i_b_addr = 16'h0010;
      tick();
      i_a_valid = 1'b0; i_b_valid = 1'b0;
      @(negedge i_clk);
      #1 i_rst = 1'b1;
      #1;
      checks++;
      if (strobes !== 4'b0000 || o_a_rvalid !== 1'b0 || o_b_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL midop_async got strb=%b rv=%b%b want 0000 00", strobes, o_a_rvalid, o_b_rvalid);
      end
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         checks++;
         if (strobes !== 4'b0000 || o_a_rvalid !== 1'b0 || o_b_rvalid !== 1'b0 || o_a_ready !== 1'b1 || o_b_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_after %0d got strb=%b rv=%b%b ready=%b%b want 0000 00 11", k, strobes, o_a_rvalid, o_b_rvalid, o_a_ready, o_b_ready);
         end
         tick();
      end
   endtask

   typedef struct {
      op_e           op;
      logic [DW-1:0] data;
      logic [DW-1:0] exp;
   } req_t;

   task automatic gen_req(input int p, output logic v, output op_e op,
                          output logic [DW-1:0] addr, output logic [DW-1:0] data);
      logic [DW-1:0] base;
      base = (p == 0) ? 16'h0100 : 16'h0200;
      v    = ($urandom_range(0, 3) != 0);
      op   = op_e'($urandom_range(0, 3));
      data = DW'($urandom);
      addr = (op == OP_FREE) ? (16'h5000 + DW'($urandom_range(0, 255))) : (base + DW'($urandom_range(0, 15)));
   endtask

   task automatic test_random();
      req_t          q_a[$];
      req_t          q_b[$];
      req_t          e;
      req_t          head;
      logic [DW-1:0] sh [2][16];
      logic          hs [2];
      logic          rv;
      logic [DW-1:0] rd;
      logic          ok;
      logic          v;
      op_e           op;
      logic [DW-1:0] ad, dt;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 16; i++) sh[p][i] = '0;
      apply_reset();
      for (int cyc = 0; cyc < 420; cyc++) begin
         if (cyc < 400) begin
            if (!i_a_valid) begin
               gen_req(0, v, op, ad, dt);
               i_a_valid = v; i_a_op = op; i_a_addr = ad; i_a_data = dt;
            end
            if (!i_b_valid) begin
               gen_req(1, v, op, ad, dt);
               i_b_valid = v; i_b_op = op; i_b_addr = ad; i_b_data = dt;
            end
         end else begin
            i_a_valid = 1'b0; i_b_valid = 1'b0;
         end
         @(negedge i_clk);
         hs[0] = i_a_valid && o_a_ready;
         hs[1] = i_b_valid && o_b_ready;
         for (int p = 0; p < 2; p++) begin
            if (hs[p]) begin
               e.op   = op_e'((p == 0) ? i_a_op : i_b_op);
               ad     = (p == 0) ? i_a_addr : i_b_addr;
               e.data = (p == 0) ? i_a_data : i_b_data;
               e.exp  = (e.op == OP_READ) ? sh[p][ad[3:0]] : '0;
               if (e.op == OP_WRITE) sh[p][ad[3:0]] = e.data;
               if (p == 0) q_a.push_back(e); else q_b.push_back(e);
            end
            rv = (p == 0) ? o_a_rvalid : o_b_rvalid;
            rd = (p == 0) ? o_a_rdata  : o_b_rdata;
            if (rv === 1'b1) begin
               checks++;
               if (((p == 0) ? q_a.size() : q_b.size()) == 0) begin
                  errors++;
                  $display("FAIL rand_extra_resp port %0d got rvalid data=%h want no response", p, rd);
               end else begin
                  if (p == 0) head = q_a.pop_front(); else head = q_b.pop_front();
                  case (head.op)
                     OP_ALLOC: ok = alloc_valid[rd] && (alloc_data[rd] == head.data) && !returned[rd];
                     OP_READ:  ok = (rd === head.exp);
                     default:  ok = (rd === 16'h0000);
                  endcase
                  if (head.op == OP_ALLOC) returned[rd] = 1'b1;
                  if (!ok) begin
                     errors++;
                     $display("FAIL rand_resp port %0d op %0d got %h want %s %h", p, head.op, rd,
                              (head.op == OP_ALLOC) ? "fresh block holding" : "word", (head.op == OP_ALLOC) ? head.data : head.exp);
                  end
               end
            end
         end
         checks++;
`ifdef HEAP_ARB_PAIR_EN
         ok = ($countones(strobes) <= 1) || (strobes == 4'b1100);
`else
         ok = ($countones(strobes) <= 1) && !(o_a_rvalid && o_b_rvalid);
`endif
         if (!ok) begin
            errors++;
            $display("FAIL rand_exclusive cycle %0d got strb=%b rv=%b%b want one op", cyc, strobes, o_a_rvalid, o_b_rvalid);
         end
         tick();
         if (hs[0]) i_a_valid = 1'b0;
         if (hs[1]) i_b_valid = 1'b0;
      end
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL rand_drain got pending a=%0d b=%0d want 0 0", q_a.size(), q_b.size());
      end
   endtask

   initial begin
      test_reset();
      test_read_write();
      test_alloc_contention();
      test_back_to_back();
      test_pair();
      test_error();
      test_reset_midop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog got timeout want completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
